// File: rtl/fsk_tx_modulator.sv
// ============================================================================
// fsk_tx_modulator: frames a byte as start/8 data/stop and keys it as phase-continuous square-wave FSK.
// Define FSK_TX_PARITY_EN to insert an even-parity symbol before stop.   Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fsk_tx_modulator #(
  parameter int MARK_HALF  = 16,
  parameter int SPACE_HALF = 32,
  parameter int BIT_CYCLES = 1024
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TX_OUT,
  output logic       TX_BIT,
  output logic       BIT_STROBE,
  output logic       BUSY
);

  localparam int HALF_MAX = (MARK_HALF > SPACE_HALF) ? MARK_HALF : SPACE_HALF;
  localparam int BW       = $clog2(BIT_CYCLES + 1);
  localparam int HW       = $clog2(HALF_MAX + 1);

  localparam logic [BW-1:0] BIT_TC   = BW'(BIT_CYCLES - 1);
  localparam logic [HW-1:0] MARK_TC  = HW'(MARK_HALF - 1);
  localparam logic [HW-1:0] SPACE_TC = HW'(SPACE_HALF - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic [HW-1:0] half_cnt, half_cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          ready_nx, busy_nx, tx_bit_nx, tx_out_nx, strobe_nx;
  logic          bit_tc;
  logic [HW-1:0] half_tc;
`ifdef FSK_TX_PARITY_EN
  logic          parity, parity_nx;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      half_cnt   <= '0;
      idx        <= '0;
      shift      <= '0;
      READY      <= 1'b0;
      BUSY       <= 1'b0;
      TX_BIT     <= 1'b1;
      TX_OUT     <= 1'b0;
      BIT_STROBE <= 1'b0;
`ifdef FSK_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      half_cnt   <= half_cnt_nx;
      idx        <= idx_nx;
      shift      <= shift_nx;
      READY      <= ready_nx;
      BUSY       <= busy_nx;
      TX_BIT     <= tx_bit_nx;
      TX_OUT     <= tx_out_nx;
      BIT_STROBE <= strobe_nx;
`ifdef FSK_TX_PARITY_EN
      parity     <= parity_nx;
`endif
    end
  end

  // Frame sequencing: every non-idle state holds for exactly BIT_CYCLES clocks.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    idx_nx     = idx;
    shift_nx   = shift;
    ready_nx   = READY;
    busy_nx    = BUSY;
    tx_bit_nx  = TX_BIT;
    strobe_nx  = 1'b0;
`ifdef FSK_TX_PARITY_EN
    parity_nx  = parity;
`endif
    bit_tc = (bit_cnt == BIT_TC);
    if (state != ST_IDLE) begin
      bit_cnt_nx = bit_tc ? '0 : bit_cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        ready_nx   = 1'b1;
        busy_nx    = 1'b0;
        tx_bit_nx  = 1'b1;
        bit_cnt_nx = '0;
        if (VALID && READY) begin
          state_nx  = ST_START;
          shift_nx  = DATA;
          ready_nx  = 1'b0;
          busy_nx   = 1'b1;
          strobe_nx = 1'b1;
          tx_bit_nx = 1'b0;
`ifdef FSK_TX_PARITY_EN
          parity_nx = ^DATA;
`endif
        end
      end
      ST_START: begin
        if (bit_tc) begin
          state_nx  = ST_DATA;
          strobe_nx = 1'b1;
          tx_bit_nx = shift[0];
          shift_nx  = {1'b0, shift[7:1]};
          idx_nx    = '0;
        end
      end
      ST_DATA: begin
        if (bit_tc) begin
          strobe_nx = 1'b1;
          if (idx == 3'd7) begin
`ifdef FSK_TX_PARITY_EN
            state_nx  = ST_PARITY;
            tx_bit_nx = parity;
`else
            state_nx  = ST_STOP;
            tx_bit_nx = 1'b1;
`endif
          end else begin
            tx_bit_nx = shift[0];
            shift_nx  = {1'b0, shift[7:1]};
            idx_nx    = idx + 3'd1;
          end
        end
      end
`ifdef FSK_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tc) begin
          state_nx  = ST_STOP;
          strobe_nx = 1'b1;
          tx_bit_nx = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tc) begin
          state_nx  = ST_IDLE;
          ready_nx  = 1'b1;
          busy_nx   = 1'b0;
          tx_bit_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Tone generator: a symbol change restarts the half-period and holds the level, so no runt pulse.
  always_comb begin
    half_tc     = TX_BIT ? MARK_TC : SPACE_TC;
    half_cnt_nx = half_cnt + 1'b1;
    tx_out_nx   = TX_OUT;
    if (tx_bit_nx != TX_BIT) begin
      half_cnt_nx = '0;
    end else if (half_cnt == half_tc) begin
      half_cnt_nx = '0;
      tx_out_nx   = ~TX_OUT;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fsk_tx_modulator.sv
// ============================================================================
// tb_fsk_tx_modulator: table-driven frame checks plus idle tone, runt-pulse and mid-frame reset sequences.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fsk_tx_modulator;

  localparam int MH = 4;
  localparam int SH = 8;
  localparam int BC = 32;
`ifdef FSK_TX_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DATA  = 8'h00;
  logic       VALID = 1'b0;
  logic       READY, TX_OUT, TX_BIT, BIT_STROBE, BUSY;

  fsk_tx_modulator #(
    .MARK_HALF (MH),
    .SPACE_HALF(SH),
    .BIT_CYCLES(BC)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .DATA      (DATA),
    .VALID     (VALID),
    .READY     (READY),
    .TX_OUT    (TX_OUT),
    .TX_BIT    (TX_BIT),
    .BIT_STROBE(BIT_STROBE),
    .BUSY      (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // seq lists the 10 non-parity symbols first-to-last, MSB = start symbol.
  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
    logic       par;
    bit         hold;
  } vec_t;

  vec_t vecs[6];

  // Minimum-pulse monitor: every TX_OUT level must last at least one mark half-period.
  bit   mon_en   = 1'b0;
  int   run_len  = -1;
  logic last_out = 1'b0;

  always @(negedge CLOCK) begin
    if (!mon_en || RESET) begin
      run_len  = -1;
      last_out = TX_OUT;
    end else if (TX_OUT != last_out) begin
      if (run_len >= 0) begin
        checks++;
        if (run_len < MH) begin
          errors++;
          $display("FAIL min_pulse: got %0d clks, expected >= %0d", run_len, MH);
        end
      end
      run_len  = 1;
      last_out = TX_OUT;
    end else if (run_len >= 0) begin
      run_len++;
    end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!READY && n < 2000) begin
      @(negedge CLOCK);
      n++;
    end
    ok = READY;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_frame(input vec_t v);
    int   sym[11];
    int   half, bad_bit, bad_stb, bad_rdy, bad_busy, bnd_bad;
    bit   ok, chk_bnd;
    logic prev_out;
    for (int i = 0; i < 9; i++) sym[i] = int'(v.seq[9-i]);
`ifdef FSK_TX_PARITY_EN
    sym[9]  = int'(v.par);
    sym[10] = int'(v.seq[0]);
`else
    sym[9]  = int'(v.seq[0]);
`endif
    wait_ready(ok);
    if (!ok) return;
    DATA  = v.data;
    VALID = 1'b1;
    @(negedge CLOCK);
    if (!v.hold) begin
      VALID = 1'b0;
      DATA  = 8'($urandom);
    end
    chk($sformatf("accept_ready_%02h", v.data), int'(READY), 0);
    chk($sformatf("accept_busy_%02h", v.data), int'(BUSY), 1);
    bad_stb  = 0;
    bad_rdy  = 0;
    bad_busy = 0;
    prev_out = TX_OUT;
    for (int s = 0; s < NSYM; s++) begin
      half    = (sym[s] != 0) ? MH : SH;
      chk_bnd = (s > 0) && (sym[s] != sym[s-1]);
      bad_bit = 0;
      bnd_bad = 0;
      for (int c = 0; c < BC; c++) begin
        if (int'(TX_BIT) != sym[s]) bad_bit++;
        if (BIT_STROBE != (c == 0)) bad_stb++;
        if (READY) bad_rdy++;
        if (!BUSY) bad_busy++;
        if (chk_bnd && c < half && TX_OUT != prev_out) bnd_bad++;
        if (chk_bnd && c == half && TX_OUT == prev_out) bnd_bad++;
        if (c == BC - 1) prev_out = TX_OUT;
        if (v.hold) DATA = 8'($urandom);
        @(negedge CLOCK);
      end
      chk($sformatf("txbit_%02h_sym%0d", v.data, s), bad_bit, 0);
      if (chk_bnd) chk($sformatf("phase_%02h_sym%0d", v.data, s), bnd_bad, 0);
    end
    chk($sformatf("strobe_%02h", v.data), bad_stb, 0);
    chk($sformatf("ready_low_%02h", v.data), bad_rdy, 0);
    chk($sformatf("busy_high_%02h", v.data), bad_busy, 0);
    chk($sformatf("end_ready_%02h", v.data), int'(READY), 1);
    chk($sformatf("end_busy_%02h", v.data), int'(BUSY), 0);
    chk($sformatf("end_txbit_%02h", v.data), int'(TX_BIT), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:11] idle_pat;
    bit          ok;
    int          n;

    vecs[0] = '{data: 8'hA5, seq: 10'b0101001011, par: 1'b0, hold: 1'b0};
    vecs[1] = '{data: 8'h00, seq: 10'b0000000001, par: 1'b0, hold: 1'b0};
    vecs[2] = '{data: 8'hFF, seq: 10'b0111111111, par: 1'b0, hold: 1'b1};
    vecs[3] = '{data: 8'h3C, seq: 10'b0001111001, par: 1'b0, hold: 1'b1};
    vecs[4] = '{data: 8'h07, seq: 10'b0111000001, par: 1'b1, hold: 1'b0};
    vecs[5] = '{data: 8'h03, seq: 10'b0110000001, par: 1'b0, hold: 1'b0};

    repeat (3) @(negedge CLOCK);
    chk("rst_ready", int'(READY), 0);
    chk("rst_txout", int'(TX_OUT), 0);
    chk("rst_txbit", int'(TX_BIT), 1);
    chk("rst_strobe", int'(BIT_STROBE), 0);
    chk("rst_busy", int'(BUSY), 0);

    // Mark tone from reset: level flips on every 4th edge after release.
    idle_pat = 12'b000111100001;
    RESET = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLOCK);
      chk($sformatf("idle_tone%0d", k), int'(TX_OUT), int'(idle_pat[k-1]));
      if (k == 1) chk("idle_ready", int'(READY), 1);
    end
    chk("idle_txbit", int'(TX_BIT), 1);
    chk("idle_busy", int'(BUSY), 0);
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) send_frame(vecs[i]);
    VALID = 1'b0;

    // Abort a frame mid-flight while TX_OUT is high.
    wait_ready(ok);
    mon_en = 1'b0;
    DATA   = 8'h55;
    VALID  = 1'b1;
    @(negedge CLOCK);
    VALID = 1'b0;
    repeat (100) @(negedge CLOCK);
    n = 0;
    while (!TX_OUT && n < 20) begin
      @(negedge CLOCK);
      n++;
    end
    chk("pre_reset_txout", int'(TX_OUT), 1);
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("abort_txout", int'(TX_OUT), 0);
    chk("abort_ready", int'(READY), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_txbit", int'(TX_BIT), 1);
    chk("abort_strobe", int'(BIT_STROBE), 0);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("rerelease_ready", int'(READY), 1);
    mon_en = 1'b1;
    send_frame(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
